// File: rtl/m_uart_rx_if.sv
// Receive-side handshake bundle of the 8N1 UART receiver: byte/valid/ready plus status pulses.
interface m_uart_rx_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    modport master (
        output o_data,
        output o_valid,
        output o_frame_err,
        output o_overrun,
        output o_busy,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_frame_err,
        input  o_overrun,
        input  o_busy,
        output i_ready
    );
endinterface

// File: rtl/m_uart_rx.sv
// UART receiver, 8N1 LSB first: synchronizes rx, mid-bit samples a frame and hands the byte over
// through a one-entry valid/ready holding register with framing-error and overrun pulses.
module m_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_rx,
    m_uart_rx_if.master   rx_if
);

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned FW   = $clog2(SYNC_STAGES + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [FW-1:0] FLUSHED  = FW'(SYNC_STAGES);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e                  state_q;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [SYNC_STAGES-1:0]  sync_d;
    logic [FW-1:0]           flush_q;
    logic [CW-1:0]           cnt_q;
    logic [2:0]              bitidx_q;
    logic [7:0]              sh_q;
    logic [7:0]              data_q;
    logic                    valid_q;
    logic                    frame_err_q;
    logic                    overrun_q;
    logic                    busy_q;
    logic                    rx_s;
    logic                    sync_flushed;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_rx};
    end

    assign rx_s         = sync_q[SYNC_STAGES-1];
    // The preset ones in the synchronizer are not real line state; WAIT_IDLE only trusts rx_s
    // once every stage has been refilled from the pin since reset.
    assign sync_flushed = (flush_q == FLUSHED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_IDLE;
            sync_q      <= '1;
            flush_q     <= '0;
            cnt_q       <= '0;
            bitidx_q    <= '0;
            sh_q        <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            sync_q      <= sync_d;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            if (!sync_flushed) begin
                flush_q <= flush_q + FW'(1);
            end

            // Consumption; a delivery in the STOP branch below overrides this clear.
            if (valid_q && rx_if.i_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                WAIT_IDLE: begin
                    if (sync_flushed && rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (!rx_s) begin
                            state_q  <= DATA;
                            cnt_q    <= '0;
                            bitidx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        sh_q     <= {rx_s, sh_q[7:1]};
                        cnt_q    <= '0;
                        bitidx_q <= bitidx_q + 3'd1;
                        if (bitidx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            if (!valid_q || rx_if.i_ready) begin
                                data_q  <= sh_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: begin
                    state_q <= WAIT_IDLE;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign rx_if.o_data      = data_q;
    assign rx_if.o_valid     = valid_q;
    assign rx_if.o_frame_err = frame_err_q;
    assign rx_if.o_overrun   = overrun_q;
    assign rx_if.o_busy      = busy_q;

endmodule
